// File: rtl/mips32_if.sv
`default_nettype none
// ============================================================================
// Module   : mips32_if
// Brief    : Observation bundle for the mips32 core (PC and run status).
// Revision : 1.0 - initial release
// ============================================================================
interface mips32_if;
    logic [31:0] pc;
    logic        halted;
    logic        taken_branch;

    modport master (output pc, halted, taken_branch);
    modport slave  (input  pc, halted, taken_branch);
endinterface
`default_nettype wire

// File: rtl/mips32.sv
`default_nettype none
// ============================================================================
// Module   : mips32
// Brief    : Five-stage pipelined MIPS32-subset core, unified 1024-word memory.
//            Define MIPS32_MUL_EN to enable the MUL instruction.
// Revision : 1.0 - initial release
// ============================================================================
module mips32 (
    input  wire logic clk1,
    input  wire logic rst,
    mips32_if.master  status
);
    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_AND   = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000011;
    localparam logic [5:0] c_OP_SLT   = 6'b000100;
`ifdef MIPS32_MUL_EN
    localparam logic [5:0] c_OP_MUL   = 6'b000101;
`endif
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_SW    = 6'b001001;
    localparam logic [5:0] c_OP_ADDI  = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011;
    localparam logic [5:0] c_OP_SLTI  = 6'b001100;
    localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0] c_OP_HLT   = 6'b111111;
    localparam logic [5:0] c_OP_NOP   = 6'b000111;

    logic [31:0] REG [0:31];
    logic [31:0] MEM [0:1023];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        r_ifid_valid;
    logic [31:0] r_ifid_ir, r_ifid_npc;
    logic        r_idex_valid;
    logic [5:0]  r_idex_op;
    logic [4:0]  r_idex_rs, r_idex_rt, r_idex_rd;
    logic [31:0] r_idex_npc, r_idex_a, r_idex_b, r_idex_imm;
    logic        r_exmem_valid, r_exmem_take, r_exmem_wen;
    logic [5:0]  r_exmem_op;
    logic [4:0]  r_exmem_dst;
    logic [31:0] r_exmem_alu, r_exmem_b;
    logic        r_memwb_valid, r_memwb_wen;
    logic [5:0]  r_memwb_op;
    logic [4:0]  r_memwb_dst;
    logic [31:0] r_memwb_data;

    logic        w_stop, w_wb_wen, w_ex_wen, w_ex_take;
    logic [4:0]  w_id_rs, w_id_rt, w_ex_dst;
    logic [31:0] w_id_a, w_id_b, w_fa, w_fb, w_ex_alu, w_mem_rdata;

    // An HLT in WB freezes the machine on the same edge that sets HALTED.
    assign w_stop   = HALTED | (r_memwb_valid & (r_memwb_op == c_OP_HLT));
    assign w_wb_wen = r_memwb_wen & ~HALTED;

    assign w_id_rs = r_ifid_ir[25:21];
    assign w_id_rt = r_ifid_ir[20:16];

    // Register read with write-through of the value retiring this cycle.
    always_comb begin
        w_id_a = REG[w_id_rs];
        w_id_b = REG[w_id_rt];
        if (w_wb_wen && r_memwb_dst == w_id_rs) w_id_a = r_memwb_data;
        if (w_wb_wen && r_memwb_dst == w_id_rt) w_id_b = r_memwb_data;
        if (w_id_rs == 5'd0) w_id_a = 32'd0;
        if (w_id_rt == 5'd0) w_id_b = 32'd0;
    end

    // EX/MEM holds only ALU results worth forwarding; a load there is not ready yet.
    always_comb begin
        w_fa = r_idex_a;
        w_fb = r_idex_b;
        if (w_wb_wen && r_memwb_dst == r_idex_rs) w_fa = r_memwb_data;
        if (w_wb_wen && r_memwb_dst == r_idex_rt) w_fb = r_memwb_data;
        if (r_exmem_wen && r_exmem_op != c_OP_LW && r_exmem_dst == r_idex_rs) w_fa = r_exmem_alu;
        if (r_exmem_wen && r_exmem_op != c_OP_LW && r_exmem_dst == r_idex_rt) w_fb = r_exmem_alu;
    end

    always_comb begin
        w_ex_alu  = 32'd0;
        w_ex_wen  = 1'b0;
        w_ex_take = 1'b0;
        w_ex_dst  = r_idex_rd;
        case (r_idex_op)
            c_OP_ADD:   begin w_ex_alu = w_fa + w_fb; w_ex_wen = 1'b1; end
            c_OP_SUB:   begin w_ex_alu = w_fa - w_fb; w_ex_wen = 1'b1; end
            c_OP_AND:   begin w_ex_alu = w_fa & w_fb; w_ex_wen = 1'b1; end
            c_OP_OR:    begin w_ex_alu = w_fa | w_fb; w_ex_wen = 1'b1; end
            c_OP_SLT:   begin w_ex_alu = {31'd0, $signed(w_fa) < $signed(w_fb)}; w_ex_wen = 1'b1; end
`ifdef MIPS32_MUL_EN
            c_OP_MUL:   begin w_ex_alu = w_fa * w_fb; w_ex_wen = 1'b1; end
`endif
            c_OP_ADDI:  begin w_ex_alu = w_fa + r_idex_imm; w_ex_wen = 1'b1; w_ex_dst = r_idex_rt; end
            c_OP_SUBI:  begin w_ex_alu = w_fa - r_idex_imm; w_ex_wen = 1'b1; w_ex_dst = r_idex_rt; end
            c_OP_SLTI:  begin
                w_ex_alu = {31'd0, $signed(w_fa) < $signed(r_idex_imm)};
                w_ex_wen = 1'b1;
                w_ex_dst = r_idex_rt;
            end
            c_OP_LW:    begin w_ex_alu = w_fa + r_idex_imm; w_ex_wen = 1'b1; w_ex_dst = r_idex_rt; end
            c_OP_SW:    w_ex_alu = w_fa + r_idex_imm;
            c_OP_BNEQZ: begin w_ex_alu = r_idex_npc + r_idex_imm; w_ex_take = (w_fa != 32'd0); end
            c_OP_BEQZ:  begin w_ex_alu = r_idex_npc + r_idex_imm; w_ex_take = (w_fa == 32'd0); end
            default:    w_ex_alu = 32'd0;
        endcase
        w_ex_wen  = w_ex_wen & r_idex_valid & (w_ex_dst != 5'd0);
        w_ex_take = w_ex_take & r_idex_valid;
    end

    assign w_mem_rdata = MEM[r_exmem_alu[9:0]];

    always_ff @(posedge clk1) begin
        if (!rst && !w_stop && r_exmem_valid && r_exmem_op == c_OP_SW)
            MEM[r_exmem_alu[9:0]] <= r_exmem_b;
    end

    always_ff @(posedge clk1) begin
        if (!rst && w_wb_wen)
            REG[r_memwb_dst] <= r_memwb_data;
    end

    // A taken branch in MEM squashes the three younger instructions behind it.
    always_ff @(posedge clk1) begin
        if (rst) begin
            PC            <= 32'd0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            r_ifid_valid  <= 1'b0;
            r_ifid_ir     <= {c_OP_NOP, 26'd0};
            r_ifid_npc    <= 32'd0;
            r_idex_valid  <= 1'b0;
            r_idex_op     <= c_OP_NOP;
            r_idex_rs     <= 5'd0;
            r_idex_rt     <= 5'd0;
            r_idex_rd     <= 5'd0;
            r_idex_npc    <= 32'd0;
            r_idex_a      <= 32'd0;
            r_idex_b      <= 32'd0;
            r_idex_imm    <= 32'd0;
            r_exmem_valid <= 1'b0;
            r_exmem_take  <= 1'b0;
            r_exmem_wen   <= 1'b0;
            r_exmem_op    <= c_OP_NOP;
            r_exmem_dst   <= 5'd0;
            r_exmem_alu   <= 32'd0;
            r_exmem_b     <= 32'd0;
            r_memwb_valid <= 1'b0;
            r_memwb_wen   <= 1'b0;
            r_memwb_op    <= c_OP_NOP;
            r_memwb_dst   <= 5'd0;
            r_memwb_data  <= 32'd0;
        end else if (w_stop) begin
            HALTED       <= 1'b1;
            TAKEN_BRANCH <= 1'b0;
        end else begin
            TAKEN_BRANCH  <= r_exmem_take;
            PC            <= r_exmem_take ? r_exmem_alu : PC + 32'd1;
            r_ifid_valid  <= ~r_exmem_take;
            r_ifid_ir     <= MEM[PC[9:0]];
            r_ifid_npc    <= PC + 32'd1;
            r_idex_valid  <= r_ifid_valid & ~r_exmem_take;
            r_idex_op     <= r_ifid_ir[31:26];
            r_idex_rs     <= w_id_rs;
            r_idex_rt     <= w_id_rt;
            r_idex_rd     <= r_ifid_ir[15:11];
            r_idex_npc    <= r_ifid_npc;
            r_idex_a      <= w_id_a;
            r_idex_b      <= w_id_b;
            r_idex_imm    <= {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
            r_exmem_valid <= r_idex_valid & ~r_exmem_take;
            r_exmem_take  <= w_ex_take & ~r_exmem_take;
            r_exmem_wen   <= w_ex_wen & ~r_exmem_take;
            r_exmem_op    <= r_idex_op;
            r_exmem_dst   <= w_ex_dst;
            r_exmem_alu   <= w_ex_alu;
            r_exmem_b     <= w_fb;
            r_memwb_valid <= r_exmem_valid;
            r_memwb_wen   <= r_exmem_wen;
            r_memwb_op    <= r_exmem_op;
            r_memwb_dst   <= r_exmem_dst;
            r_memwb_data  <= (r_exmem_op == c_OP_LW) ? w_mem_rdata : r_exmem_alu;
        end
    end

    assign status.pc           = PC;
    assign status.halted       = HALTED;
    assign status.taken_branch = TAKEN_BRANCH;
endmodule
`default_nettype wire

// File: tb/tb_mips32.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32
// Brief    : Directed programs with hand-computed results for the mips32 core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32;
    localparam logic [5:0] c_ADD   = 6'b000000;
    localparam logic [5:0] c_SUB   = 6'b000001;
    localparam logic [5:0] c_OR    = 6'b000011;
    localparam logic [5:0] c_MUL   = 6'b000101;
    localparam logic [5:0] c_NOP7  = 6'b000111;
    localparam logic [5:0] c_LW    = 6'b001000;
    localparam logic [5:0] c_SW    = 6'b001001;
    localparam logic [5:0] c_ADDI  = 6'b001010;
    localparam logic [5:0] c_SUBI  = 6'b001011;
    localparam logic [5:0] c_BNEQZ = 6'b001101;
    localparam logic [5:0] c_HLT   = 6'b111111;
`ifdef MIPS32_MUL_EN
    localparam logic [31:0] c_FACT_EXP = 32'd5040;
    localparam logic [31:0] c_MUL_EXP  = 32'd42;
`else
    localparam logic [31:0] c_FACT_EXP = 32'd1;
    localparam logic [31:0] c_MUL_EXP  = 32'd8;
`endif

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   taken_cnt = 0;

    mips32_if st ();
    mips32 dut (.clk1(clk1), .rst(rst), .status(st));

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Holds reset, clears memory and preloads REG[k]=k; caller writes the program next.
    task automatic begin_program();
        rst = 1'b1;
        @(negedge clk1);
        for (int i = 0; i < 1024; i++) dut.MEM[i] <= 32'd0;
        for (int k = 0; k < 32; k++) dut.REG[k] <= 32'(k);
        @(negedge clk1);
    endtask

    task automatic run_to_halt(input int budget, input string tag);
        int n = 0;
        taken_cnt = 0;
        rst = 1'b0;
        while (st.halted !== 1'b1 && n < budget) begin
            @(negedge clk1);
            n++;
            if (st.taken_branch === 1'b1) taken_cnt++;
        end
        check({tag, "_halted"}, {31'd0, st.halted}, 32'd1);
    endtask

    task automatic load_factorial();
        dut.REG[11] <= 32'd0;
        dut.MEM[200] <= 32'd7;
        dut.MEM[0] <= ri(c_ADDI, 5'd10, 5'd0, 16'd200);
        dut.MEM[1] <= ri(c_ADDI, 5'd2, 5'd0, 16'd1);
        dut.MEM[2] <= ri(c_LW, 5'd3, 5'd10, 16'd0);
        dut.MEM[3] <= rr(c_OR, 5'd20, 5'd20, 5'd20);
        dut.MEM[4] <= rr(c_MUL, 5'd2, 5'd2, 5'd3);
        dut.MEM[5] <= ri(c_SUBI, 5'd3, 5'd3, 16'd1);
        dut.MEM[6] <= ri(c_BNEQZ, 5'd0, 5'd3, 16'hFFFD);
        dut.MEM[7] <= ri(c_ADDI, 5'd11, 5'd11, 16'd1);
        dut.MEM[8] <= ri(c_SW, 5'd2, 5'd10, 16'hFFFE);
        dut.MEM[9] <= {c_HLT, 26'd0};
    endtask

    initial begin
        // Basic ALU program with exact halt timing.
        begin_program();
        check("rst_pc", st.pc, 32'd0);
        check("rst_halted", {31'd0, st.halted}, 32'd0);
        check("rst_taken", {31'd0, st.taken_branch}, 32'd0);
        dut.MEM[0] <= ri(c_ADDI, 5'd1, 5'd0, 16'd10);
        dut.MEM[1] <= ri(c_ADDI, 5'd2, 5'd0, 16'd20);
        dut.MEM[2] <= ri(c_ADDI, 5'd3, 5'd0, 16'd25);
        dut.MEM[3] <= rr(c_OR, 5'd15, 5'd7, 5'd7);
        dut.MEM[4] <= rr(c_OR, 5'd15, 5'd7, 5'd7);
        dut.MEM[5] <= rr(c_ADD, 5'd4, 5'd1, 5'd2);
        dut.MEM[6] <= rr(c_OR, 5'd15, 5'd7, 5'd7);
        dut.MEM[7] <= rr(c_ADD, 5'd5, 5'd4, 5'd3);
        dut.MEM[8] <= {c_HLT, 26'd0};
        rst = 1'b0;
        repeat (12) @(negedge clk1);
        check("alu_halted_c12", {31'd0, st.halted}, 32'd0);
        @(negedge clk1);
        check("alu_halted_c13", {31'd0, st.halted}, 32'd1);
        check("alu_pc_at_halt", st.pc, 32'd12);
        check("alu_r1", dut.REG[1], 32'd10);
        check("alu_r2", dut.REG[2], 32'd20);
        check("alu_r3", dut.REG[3], 32'd25);
        check("alu_r4", dut.REG[4], 32'd30);
        check("alu_r5", dut.REG[5], 32'd55);
        check("alu_r15", dut.REG[15], 32'd7);
        check("alu_r0", dut.REG[0], 32'd0);
        repeat (5) @(negedge clk1);
        check("alu_pc_frozen", st.pc, 32'd12);
        check("alu_still_halted", {31'd0, st.halted}, 32'd1);

        // Back-to-back dependencies resolved purely by forwarding.
        begin_program();
        dut.MEM[0] <= ri(c_ADDI, 5'd1, 5'd0, 16'd7);
        dut.MEM[1] <= rr(c_ADD, 5'd2, 5'd1, 5'd1);
        dut.MEM[2] <= rr(c_SUB, 5'd3, 5'd2, 5'd1);
        dut.MEM[3] <= {c_HLT, 26'd0};
        run_to_halt(100, "dep");
        check("dep_r1", dut.REG[1], 32'd7);
        check("dep_r2", dut.REG[2], 32'd14);
        check("dep_r3", dut.REG[3], 32'd7);

        // Load, use after one spacer, store, then load back the stored word.
        begin_program();
        dut.REG[1] <= 32'd120;
        dut.MEM[120] <= 32'd85;
        dut.MEM[0] <= ri(c_LW, 5'd2, 5'd1, 16'd0);
        dut.MEM[1] <= {c_NOP7, 26'd0};
        dut.MEM[2] <= ri(c_ADDI, 5'd2, 5'd2, 16'd45);
        dut.MEM[3] <= ri(c_SW, 5'd2, 5'd1, 16'd1);
        dut.MEM[4] <= ri(c_LW, 5'd4, 5'd1, 16'd1);
        dut.MEM[5] <= {c_NOP7, 26'd0};
        dut.MEM[6] <= {c_HLT, 26'd0};
        run_to_halt(100, "mem");
        check("mem_m121", dut.MEM[121], 32'd130);
        check("mem_m120", dut.MEM[120], 32'd85);
        check("mem_r2", dut.REG[2], 32'd130);
        check("mem_r4_sw_then_lw", dut.REG[4], 32'd130);

        // Factorial loop: six taken branches, slots 7..9 squashed each time.
        begin_program();
        load_factorial();
        run_to_halt(300, "fact");
        check("fact_m198", dut.MEM[198], c_FACT_EXP);
        check("fact_r3", dut.REG[3], 32'd0);
        check("fact_r11_once", dut.REG[11], 32'd1);
        check("fact_taken_pulses", 32'(taken_cnt), 32'd6);

        // Reset in the middle of the loop, then rerun from PC 0.
        begin_program();
        load_factorial();
        rst = 1'b0;
        repeat (25) @(negedge clk1);
        check("mid_not_halted", {31'd0, st.halted}, 32'd0);
        rst = 1'b1;
        @(negedge clk1);
        check("mid_rst_pc", st.pc, 32'd0);
        check("mid_rst_halted", {31'd0, st.halted}, 32'd0);
        check("mid_rst_taken", {31'd0, st.taken_branch}, 32'd0);
        check("mid_rst_m198", dut.MEM[198], 32'd0);
        check("mid_rst_r11", dut.REG[11], 32'd0);
        @(negedge clk1);
        run_to_halt(300, "rerun");
        check("rerun_m198", dut.MEM[198], c_FACT_EXP);
        check("rerun_r11", dut.REG[11], 32'd1);
        check("rerun_taken_pulses", 32'(taken_cnt), 32'd6);

        // R0 writes, unknown opcode, MUL build option, write-through read.
        begin_program();
        dut.MEM[0] <= ri(c_ADDI, 5'd0, 5'd0, 16'd5);
        dut.MEM[1] <= rr(c_ADD, 5'd12, 5'd0, 5'd0);
        dut.MEM[2] <= {c_NOP7, 5'd1, 5'd9, 5'd9, 11'd0};
        dut.MEM[3] <= rr(c_MUL, 5'd8, 5'd6, 5'd7);
        dut.MEM[4] <= ri(c_ADDI, 5'd13, 5'd0, 16'd3);
        dut.MEM[5] <= {c_NOP7, 26'd0};
        dut.MEM[6] <= {c_NOP7, 26'd0};
        dut.MEM[7] <= rr(c_ADD, 5'd14, 5'd13, 5'd13);
        dut.MEM[8] <= {c_HLT, 26'd0};
        run_to_halt(100, "edge");
        check("edge_r0", dut.REG[0], 32'd0);
        check("edge_r12_no_r0_fwd", dut.REG[12], 32'd0);
        check("edge_r9_op7", dut.REG[9], 32'd9);
        check("edge_r1_op7", dut.REG[1], 32'd1);
        check("edge_r8_mul", dut.REG[8], c_MUL_EXP);
        check("edge_r14_writethru", dut.REG[14], 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
